// File: rtl/mem_map_pkg.sv
// ============================================================================
// mem_map_pkg : address map, boot vectors and read-FSM encoding shared by the
//               CPU memory-port responder and its testbench.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_map_pkg;

    localparam logic [15:0] GPIO_ADDR   = 16'hFF00;
    localparam logic [15:0] CYCLES_ADDR = 16'hFF04;
    localparam logic [15:0] STATUS_ADDR = 16'hFF08;

    localparam logic [15:0] VEC_RESET   = 16'h0080;
    localparam logic [15:0] VEC_SP      = 16'h0084;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rd_state_e;

    function automatic logic [15:0] word_align(input logic [15:0] addr);
        return {addr[15:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_sp.sv
// ============================================================================
// ram_sp : single-port RAM, synchronous read-first access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_sp #(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read-first: a read and write to the same word in one edge returns old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : CPU memory-port responder with RAM, GPIO, cycle counter and
//                 status register; fixed-latency read responses.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_responder
    import mem_map_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int RD_LATENCY = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic [15:0] i_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [7:0]  gpio_out,
    output logic        err
);

    localparam int          AW         = $clog2(MEM_WORDS);
    localparam int          LAT_LOAD_I = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [2:0]  LAT_LOAD   = LAT_LOAD_I[2:0];

    rd_state_e   state_q;
    logic [2:0]  lat_cnt_q;
    logic        rd_valid_q;
    logic [31:0] rd_data_q;
    logic        src_ram_q;
    logic [31:0] snap_q;

    logic [7:0]  gpio_q,   gpio_d;
    logic [31:0] cycles_q, cycles_d;
    logic        err_q,    err_d;

    logic [15:0] w_word_addr;
    logic        w_is_ram, w_is_gpio, w_is_cycles, w_is_status, w_mapped;
    logic        w_misalign, w_accept, w_collide, w_err_set, w_err_clr;
    logic [31:0] w_reg_rdata;
    logic [31:0] w_ram_rdata;

    assign w_word_addr = word_align(i_addr);
    assign w_is_ram    = int'({18'd0, i_addr[15:2]}) < MEM_WORDS;
    assign w_is_gpio   = (w_word_addr == GPIO_ADDR);
    assign w_is_cycles = (w_word_addr == CYCLES_ADDR);
    assign w_is_status = (w_word_addr == STATUS_ADDR);
    assign w_mapped    = w_is_ram | w_is_gpio | w_is_cycles | w_is_status;
    assign w_misalign  = |i_addr[1:0];

    assign w_accept  = (state_q == ST_IDLE) && rd_en && !wr_en;
    assign w_collide = (state_q == ST_IDLE) && rd_en && wr_en;
    assign w_err_set = ((w_accept || wr_en) && (w_misalign || !w_mapped)) || w_collide;
    assign w_err_clr = wr_en && w_is_status && wr_data[0];

    always_comb begin
        w_reg_rdata = 32'd0;
        if (w_is_gpio) begin
            w_reg_rdata = {24'd0, gpio_q};
        end else if (w_is_cycles) begin
            w_reg_rdata = cycles_q;
        end else if (w_is_status) begin
            w_reg_rdata = {31'd0, err_q};
        end
    end

    // A new error raised in the same cycle as a clear takes priority.
    always_comb begin
        err_d    = w_err_set ? 1'b1 : (w_err_clr ? 1'b0 : err_q);
        gpio_d   = (wr_en && w_is_gpio) ? wr_data[7:0] : gpio_q;
        cycles_d = cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q   <= 8'd0;
            cycles_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            gpio_q   <= gpio_d;
            cycles_q <= cycles_d;
            err_q    <= err_d;
        end
    end

    ram_sp #(
        .DEPTH     (MEM_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en && w_is_ram),
        .re_i    (w_accept && w_is_ram),
        .addr_i  (i_addr[AW+1:2]),
        .wdata_i (wr_data),
        .rdata_o (w_ram_rdata)
    );

    // Register sources are snapshotted at accept so later writes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= 3'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            src_ram_q  <= 1'b0;
            snap_q     <= 32'd0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        src_ram_q <= w_is_ram;
                        snap_q    <= w_reg_rdata;
                        if (RD_LATENCY > 1) begin
                            state_q   <= ST_WAIT;
                            lat_cnt_q <= LAT_LOAD;
                        end else begin
                            state_q   <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q == 3'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= src_ram_q ? w_ram_rdata : snap_q;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign gpio_out = gpio_q;
    assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : three responders (latency 1, 3, 4) checked against a
//                    behavioural model of the memory map.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;
    import mem_map_pkg::*;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en_a   [ND];
    logic        wr_en_a   [ND];
    logic [15:0] addr_a    [ND];
    logic [31:0] wdata_a   [ND];
    logic [31:0] rd_data_w [ND];
    logic        rd_valid_w[ND];
    logic [7:0]  gpio_w    [ND];
    logic        err_w     [ND];

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [ND][1024];
    logic [7:0]  gpio_m [ND];
    logic        err_m  [ND];
    logic [31:0] tb_cyc;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_dut
            mem_responder #(
                .MEM_WORDS  (1024),
                .RD_LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 4)),
                .INIT_FILE  ("")
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .rd_en    (rd_en_a[g]),
                .i_addr   (addr_a[g]),
                .rd_data  (rd_data_w[g]),
                .rd_valid (rd_valid_w[g]),
                .wr_en    (wr_en_a[g]),
                .wr_data  (wdata_a[g]),
                .gpio_out (gpio_w[g]),
                .err      (err_w[g])
            );
        end
    endgenerate

    // Free-running reference count of clock edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_mapped(input logic [15:0] a);
        logic [15:0] wa;
        wa = {a[15:2], 2'b00};
        return (a < 16'h1000) || wa == GPIO_ADDR || wa == CYCLES_ADDR || wa == STATUS_ADDR;
    endfunction

    task automatic m_read(input int d, input logic [15:0] a, output logic [31:0] v);
        logic [15:0] wa;
        wa = {a[15:2], 2'b00};
        v  = 32'd0;
        if (a < 16'h1000)             v = mem_m[d][int'(a[11:2])];
        else if (wa == GPIO_ADDR)     v = {24'd0, gpio_m[d]};
        else if (wa == CYCLES_ADDR)   v = tb_cyc;
        else if (wa == STATUS_ADDR)   v = {31'd0, err_m[d]};
        if (a[1:0] != 2'b00 || !m_mapped(a)) err_m[d] = 1'b1;
    endtask

    task automatic m_write(input int d, input logic [15:0] a, input logic [31:0] v);
        logic [15:0] wa;
        wa = {a[15:2], 2'b00};
        if (a < 16'h1000)             mem_m[d][int'(a[11:2])] = v;
        else if (wa == GPIO_ADDR)     gpio_m[d] = v[7:0];
        else if (wa == STATUS_ADDR && v[0]) err_m[d] = 1'b0;
        if (a[1:0] != 2'b00 || !m_mapped(a)) err_m[d] = 1'b1;
    endtask

    task automatic do_write(input int d, input logic [15:0] a, input logic [31:0] v);
        @(negedge clk);
        wr_en_a[d] = 1'b1; addr_a[d] = a; wdata_a[d] = v;
        m_write(d, a, v);
        @(negedge clk);
        wr_en_a[d] = 1'b0;
    endtask

    task automatic do_read(input int d, input logic [15:0] a, output logic [31:0] got);
        logic [31:0] exp;
        int lat;
        @(negedge clk);
        rd_en_a[d] = 1'b1; addr_a[d] = a;
        m_read(d, a, exp);
        @(negedge clk);
        rd_en_a[d] = 1'b0;
        addr_a[d]  = 16'hDEAD;
        lat = 0;
        while (!rd_valid_w[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = rd_data_w[d];
        chk($sformatf("rd_lat d%0d a%h", d, a), lat, lat_of(d));
        chk($sformatf("rd_data d%0d a%h", d, a), got, exp);
        @(negedge clk);
        chk($sformatf("rd_valid_pulse d%0d", d), {31'd0, rd_valid_w[d]}, 32'd0);
    endtask

    task automatic chk_state(input int d, input string tag);
        chk($sformatf("%s err d%0d", tag, d), {31'd0, err_w[d]}, {31'd0, err_m[d]});
        chk($sformatf("%s gpio d%0d", tag, d), {24'd0, gpio_w[d]}, {24'd0, gpio_m[d]});
    endtask

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [31:0] got;
        logic [31:0] dat [2];
        int          t   [2];
        int          nresp, cyc, pulses;

        for (int d = 0; d < ND; d++) begin
            rd_en_a[d] = 0; wr_en_a[d] = 0; addr_a[d] = 0; wdata_a[d] = 0;
            gpio_m[d] = 0; err_m[d] = 0;
            for (int w = 0; w < 1024; w++) mem_m[d][w] = 32'd0;
        end

        vecs[0]  = '{1, 16'h0080, 32'h0000_0200, 32'h0,          0, 8'h00};
        vecs[1]  = '{0, 16'h0080, 32'h0,         32'h0000_0200, 0, 8'h00};
        vecs[2]  = '{1, 16'h0010, 32'hCAFE_F00D, 32'h0,          0, 8'h00};
        vecs[3]  = '{0, 16'h0010, 32'h0,         32'hCAFE_F00D, 0, 8'h00};
        vecs[4]  = '{1, 16'hFF00, 32'h0000_01A5, 32'h0,          0, 8'hA5};
        vecs[5]  = '{0, 16'hFF00, 32'h0,         32'h0000_00A5, 0, 8'hA5};
        vecs[6]  = '{1, 16'hFF04, 32'h1234_5678, 32'h0,          0, 8'hA5};
        vecs[7]  = '{0, 16'hFFFF, 32'h0,         32'h0,          1, 8'hA5};
        vecs[8]  = '{0, 16'hFF08, 32'h0,         32'h0000_0001, 1, 8'hA5};
        vecs[9]  = '{1, 16'hFF08, 32'h0000_0001, 32'h0,          0, 8'hA5};
        vecs[10] = '{0, 16'h0083, 32'h0,         32'h0000_0200, 1, 8'hA5};
        vecs[11] = '{1, 16'hFF09, 32'h0000_0001, 32'h0,          1, 8'hA5};
        vecs[12] = '{1, 16'hFF08, 32'h0000_0000, 32'h0,          1, 8'hA5};
        vecs[13] = '{1, 16'hFF08, 32'h0000_0001, 32'h0,          0, 8'hA5};
        vecs[14] = '{0, 16'h1000, 32'h0,         32'h0,          1, 8'hA5};
        vecs[15] = '{1, 16'h1000, 32'h5555_5555, 32'h0,          1, 8'hA5};
        vecs[16] = '{1, 16'hFF08, 32'h0000_0001, 32'h0,          0, 8'hA5};
        vecs[17] = '{0, 16'hFF08, 32'h0,         32'h0,          0, 8'hA5};

        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset rd_valid d%0d", d), {31'd0, rd_valid_w[d]}, 32'd0);
            chk($sformatf("reset rd_data d%0d", d), rd_data_w[d], 32'd0);
            chk_state(d, "reset");
        end
        rst_n = 1'b1;

        // Directed table on the latency-1 responder.
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(0, vecs[i].addr, vecs[i].data);
            end else begin
                do_read(0, vecs[i].addr, got);
                chk($sformatf("vec%0d rd", i), got, vecs[i].exp_rd);
            end
            chk($sformatf("vec%0d err", i), {31'd0, err_w[0]}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d gpio", i), {24'd0, gpio_w[0]}, {24'd0, vecs[i].exp_gpio});
        end

        // Two CYCLES reads: difference equals the accept spacing.
        do_read(0, CYCLES_ADDR, dat[0]);
        repeat (5) @(negedge clk);
        do_read(0, CYCLES_ADDR, dat[1]);
        chk("cycles_delta", dat[1] - dat[0], 32'd9);

        // Read and write together in IDLE, then rd_en held after wr_en drops.
        @(negedge clk);
        rd_en_a[0] = 1; wr_en_a[0] = 1; addr_a[0] = 16'h0020; wdata_a[0] = 32'h55;
        m_write(0, 16'h0020, 32'h55);
        err_m[0] = 1'b1;
        @(negedge clk);
        chk("collide no_valid", {31'd0, rd_valid_w[0]}, 32'd0);
        chk("collide err", {31'd0, err_w[0]}, 32'd1);
        wr_en_a[0] = 0;
        @(negedge clk);
        rd_en_a[0] = 0;
        @(negedge clk);
        chk("collide late_valid", {31'd0, rd_valid_w[0]}, 32'd1);
        chk("collide late_data", rd_data_w[0], 32'h55);
        do_write(0, STATUS_ADDR, 32'h1);
        chk_state(0, "after_collide");

        // Latency 3, rd_en held, address switched in the rd_valid cycle.
        do_write(1, VEC_RESET, 32'h0000_0200);
        do_write(1, VEC_SP,    32'h0000_0300);
        @(negedge clk);
        rd_en_a[1] = 1; addr_a[1] = VEC_RESET;
        nresp = 0; cyc = 0; t[0] = 0; t[1] = 0; dat[0] = 0; dat[1] = 0;
        while (nresp < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rd_valid_w[1]) begin
                t[nresp] = cyc; dat[nresp] = rd_data_w[1]; nresp++;
                if (nresp == 1) addr_a[1] = VEC_SP;
                else            rd_en_a[1] = 0;
            end
        end
        rd_en_a[1] = 0;
        chk("b2b count", nresp, 2);
        chk("b2b first_lat", t[0], 4);
        chk("b2b spacing", t[1] - t[0], 4);
        chk("b2b data0", dat[0], 32'h0000_0200);
        chk("b2b data1", dat[1], 32'h0000_0300);
        @(negedge clk);

        // Write to the word of a pending read: read returns pre-write data.
        do_write(1, 16'h0010, 32'hCAFE_F00D);
        @(negedge clk);
        rd_en_a[1] = 1; addr_a[1] = 16'h0010;
        @(negedge clk);
        rd_en_a[1] = 0; wr_en_a[1] = 1; wdata_a[1] = 32'h1111_1111;
        m_write(1, 16'h0010, 32'h1111_1111);
        @(negedge clk);
        wr_en_a[1] = 0;
        cyc = 1;
        while (!rd_valid_w[1] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("pending_wr lat", cyc, 3);
        chk("pending_wr data", rd_data_w[1], 32'hCAFE_F00D);
        do_read(1, 16'h0010, got);

        // Reset during WAIT on the latency-4 responder.
        do_write(2, 16'h0040, 32'h0000_1234);
        @(negedge clk);
        rd_en_a[2] = 1; addr_a[2] = 16'h0040;
        @(negedge clk);
        rd_en_a[2] = 0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            gpio_m[d] = 0; err_m[d] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_valid_w[2]) pulses++;
        end
        chk("rst_mid no_valid", pulses, 0);
        chk("rst_mid rd_data", rd_data_w[2], 32'd0);
        for (int d = 0; d < ND; d++) chk_state(d, "rst_mid");
        do_read(2, 16'h0040, got);

        // Randomized traffic against the model on every responder.
        for (int d = 0; d < ND; d++) begin
            for (int w = 0; w < 32; w++) do_write(d, 16'(w * 4), $urandom);
            for (int n = 0; n < 40; n++) begin
                logic [15:0] a;
                int sel;
                sel = $urandom_range(0, 9);
                case (sel)
                    6:       a = GPIO_ADDR;
                    7:       a = CYCLES_ADDR;
                    8:       a = STATUS_ADDR;
                    9:       a = 16'h2000 + 16'($urandom_range(0, 255) * 4);
                    default: a = 16'($urandom_range(0, 31) * 4);
                endcase
                if (sel == 5) a = a + 16'($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 1) do_write(d, a, $urandom);
                else                           do_read(d, a, got);
                chk_state(d, "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
